// File: rtl/gru_seq_feeder.sv
// gru_seq_feeder: ping-pong sequence buffer that streams stored timesteps to a GRU cell.
// Define GRU_SEQ_FEEDER_ZERO_PAD_EN to zero-pad sequences terminated early by in_last.
module gru_seq_feeder #(
    parameter int WIDTH   = 4,
    parameter int X_SIZE  = 6,
    parameter int SEQ_LEN = 15
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [X_SIZE-1:0][WIDTH-1:0] in_row,
    input  logic                                in_last,
    output logic                                x_valid,
    input  logic                                x_ready,
    output logic signed [X_SIZE-1:0][WIDTH-1:0] x_t,
    output logic                                x_first,
    output logic                                x_last,
    output logic [4:0]                          x_idx
);
    localparam int AW = SEQ_LEN > 1 ? $clog2(SEQ_LEN) : 1;
    localparam logic [AW-1:0] LAST = AW'(SEQ_LEN - 1);

    typedef logic [X_SIZE-1:0][WIDTH-1:0] row_t;
`ifdef GRU_SEQ_FEEDER_ZERO_PAD_EN
    typedef enum logic {WFILL, WPAD} wstate_e;
`else
    typedef enum logic {WFILL} wstate_e;
    logic unused_in_last;
    assign unused_in_last = in_last;
`endif
    typedef enum logic {RIDLE, RSTREAM} rstate_e;

    row_t          mem_q [2][SEQ_LEN];
    wstate_e       wr_state_q, wr_state_d;
    rstate_e       rd_state_q, rd_state_d;
    logic [1:0]    full_q, full_d;
    logic [AW-1:0] wr_row_q, wr_row_d, rd_row_q, rd_row_d;
    logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic          acc, wr_en, wr_done, xfer, rd_done;
    row_t          wr_data;

    assign in_ready = !full_q[wr_bank_q] && wr_state_q == WFILL;
    assign acc      = in_valid && in_ready;
    assign x_valid  = rd_state_q == RSTREAM;
    assign x_t      = x_valid ? mem_q[rd_bank_q][rd_row_q] : '0;
    assign x_idx    = x_valid ? 5'(rd_row_q) : '0;
    assign x_first  = x_valid && rd_row_q == '0;
    assign x_last   = x_valid && rd_row_q == LAST;
    assign xfer     = x_valid && x_ready;
    assign rd_done  = xfer && rd_row_q == LAST;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_en      = acc;
        wr_data    = in_row;
        wr_done    = acc && wr_row_q == LAST;
`ifdef GRU_SEQ_FEEDER_ZERO_PAD_EN
        if (wr_state_q == WPAD) begin
            wr_en   = 1'b1;
            wr_data = '0;
            wr_done = wr_row_q == LAST;
        end
        if (acc && in_last && wr_row_q != LAST) wr_state_d = WPAD;
        if (wr_done) wr_state_d = WFILL;
`endif
        wr_row_d  = wr_en ? (wr_done ? '0 : wr_row_q + 1'b1) : wr_row_q;
        wr_bank_d = wr_done ? ~wr_bank_q : wr_bank_q;
    end

    // Set and release always hit different banks, so both may apply in one cycle.
    always_comb begin
        full_d = full_q;
        if (wr_done) full_d[wr_bank_q] = 1'b1;
        if (rd_done) full_d[rd_bank_q] = 1'b0;
        rd_row_d   = xfer ? (rd_done ? '0 : rd_row_q + 1'b1) : rd_row_q;
        rd_bank_d  = rd_done ? ~rd_bank_q : rd_bank_q;
        rd_state_d = full_d[rd_bank_d] ? RSTREAM : RIDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state_q <= WFILL;
            rd_state_q <= RIDLE;
            full_q     <= '0;
            wr_row_q   <= '0;
            rd_row_q   <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            full_q     <= full_d;
            wr_row_q   <= wr_row_d;
            rd_row_q   <= rd_row_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_bank_q][wr_row_q] <= wr_data;
    end
endmodule

// File: tb/tb_gru_seq_feeder.sv
// tb_gru_seq_feeder: randomized bench comparing gru_seq_feeder against a queue-based sequence model.
// Honors GRU_SEQ_FEEDER_ZERO_PAD_EN in the model when the design is built with it.
module tb_gru_seq_feeder;
    localparam int WIDTH = 4, X_SIZE = 6, SEQ_LEN = 15, ROWW = WIDTH * X_SIZE;
    typedef logic [ROWW-1:0] row_t;

    logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, x_ready = 1'b0;
    row_t in_row = '0;
    logic in_ready, x_valid, x_first, x_last;
    row_t x_t;
    logic [4:0] x_idx;

    int n_chk = 0, n_pass = 0;
    row_t part[$];
    row_t stq[$];
    int pos = 0;
    bit pad = 1'b0;

    always #5 clk = ~clk;

    gru_seq_feeder #(.WIDTH(WIDTH), .X_SIZE(X_SIZE), .SEQ_LEN(SEQ_LEN)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_row(in_row), .in_last(in_last), .x_valid(x_valid), .x_ready(x_ready),
        .x_t(x_t), .x_first(x_first), .x_last(x_last), .x_idx(x_idx)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic row_t rnd_row();
        logic [31:0] r = $urandom;
        return r[ROWW-1:0];
    endfunction

    // Stored sequences are a flat row queue; the head sequence is being streamed at pos.
    task automatic model_step();
        bit rdy = stq.size() < 2 * SEQ_LEN && !pad;
        bit acc = in_valid && rdy;
        bit xf  = stq.size() >= SEQ_LEN && x_ready;
        if (xf) begin
            if (pos == SEQ_LEN - 1) begin
                for (int i = 0; i < SEQ_LEN; i++) void'(stq.pop_front());
                pos = 0;
            end else pos++;
        end
        if (pad) part.push_back('0);
        else if (acc) begin
            part.push_back(in_row);
`ifdef GRU_SEQ_FEEDER_ZERO_PAD_EN
            if (in_last && part.size() < SEQ_LEN) pad = 1'b1;
`endif
        end
        if (part.size() == SEQ_LEN) begin
            foreach (part[i]) stq.push_back(part[i]);
            part.delete();
            pad = 1'b0;
        end
    endtask

    task automatic compare();
        bit v = stq.size() >= SEQ_LEN;
        chk("in_ready", 32'(in_ready), 32'(stq.size() < 2 * SEQ_LEN && !pad));
        chk("x_valid", 32'(x_valid), 32'(v));
        if (v) begin
            chk("x_t", 32'(x_t), 32'(stq[pos]));
            chk("x_idx", 32'(x_idx), 32'(pos));
            chk("x_first", 32'(x_first), 32'(pos == 0));
            chk("x_last", 32'(x_last), 32'(pos == SEQ_LEN - 1));
        end
    endtask

    task automatic cycle(bit v, row_t row, bit last, bit xr);
        in_valid = v;
        in_row   = row;
        in_last  = last;
        x_ready  = xr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic run(int n, int pv, int pr, int pl);
        for (int i = 0; i < n; i++)
            cycle($urandom_range(99) < pv, rnd_row(), $urandom_range(99) < pl, $urandom_range(99) < pr);
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        in_valid = 1'b0;
        x_ready  = 1'b0;
        #1;
        chk("rst_x_valid", 32'(x_valid), 0);
        chk("rst_x_idx", 32'(x_idx), 0);
        chk("rst_x_t", 32'(x_t), 0);
        chk("rst_x_first", 32'(x_first), 0);
        chk("rst_x_last", 32'(x_last), 0);
        stq.delete();
        part.delete();
        pos = 0;
        pad = 1'b0;
        @(posedge clk);
        #1 chk("rst_hold_valid", 32'(x_valid), 0);
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic push_ramp();
        row_t r;
        for (int k = 0; k < SEQ_LEN; k++) begin
            for (int f = 0; f < X_SIZE; f++) r[f*WIDTH +: WIDTH] = WIDTH'(k);
            cycle(1'b1, r, k == SEQ_LEN - 1, 1'b1);
        end
    endtask

    initial begin
        pulse_reset();
        push_ramp();
        run(20, 0, 100, 0);
        for (int i = 0; i < 55; i++) cycle(1'b1, rnd_row(), 1'b0, 1'b0);
        run(10, 0, 0, 0);
        for (int i = 0; i < 70; i++) cycle(1'b1, rnd_row(), 1'b0, 1'b1);
        run(40, 0, 100, 0);
        for (int i = 0; i < 40; i++) cycle(1'b1, rnd_row(), 1'b0, i % 2 == 0);
        run(40, 0, 100, 0);
        for (int k = 0; k < 5; k++) cycle(1'b1, rnd_row(), k == 4, 1'b1);
        run(12, 0, 100, 0);
        for (int k = 0; k < 10; k++) cycle(1'b1, rnd_row(), 1'b0, 1'b1);
        run(40, 0, 100, 0);
        run(300, 90, 90, 5);
        run(300, 90, 20, 5);
        run(300, 30, 90, 10);
        run(300, 70, 50, 3);
        begin
            int i = 0;
            while (i < 500 && !(stq.size() >= SEQ_LEN && pos == 7)) begin
                cycle(1'b1, rnd_row(), 1'b0, 1'b1);
                i++;
            end
            chk("reach_idx7", 32'(i < 500), 1);
        end
        pulse_reset();
        push_ramp();
        run(30, 0, 100, 0);
        run(400, 80, 60, 4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
